gcd_arbiter: RTL and testbench

GCD_ARBITER -- requirements
Module: gcd_arbiter

---
 rtl/gcd_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_gcd_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gcd_arbiter
// Purpose  : Round-robin arbiter that shares one external GCD engine among
//            N requesters. Zero operands are answered directly without
//            using the engine. A stuck engine is aborted after TIMEOUT wait
//            cycles.
// Ports    : clk, rst          - clock, asynchronous active-high reset
//            req[N]            - per-requester request (held until ack)
//            xin/yin[N*W]      - packed operands, lane i at [i*W +: W]
//            ack[N]            - one-hot, one-cycle completion pulse
//            result[W], err    - GCD result / timeout flag, valid with ack
//            busy              - high whenever the FSM is not idle
//            eng_load          - one-cycle engine load strobe
//            eng_x/eng_y[W]    - engine operands, held until completion
//            eng_done, eng_gcd - engine completion flag and result
// Revision : 1.0 - initial release
// ============================================================================
module gcd_arbiter #(
    parameter int N       = 4,
    parameter int W       = 8,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] xin,
    input  logic [N*W-1:0] yin,
    output logic [N-1:0]   ack,
    output logic [W-1:0]   result,
    output logic           err,
    output logic           busy,
    output logic           eng_load,
    output logic [W-1:0]   eng_x,
    output logic [W-1:0]   eng_y,
    input  logic           eng_done,
    input  logic [W-1:0]   eng_gcd
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    // Wait counter is sized from TIMEOUT only, never narrower than 8 bits.
    localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
    // The counter starts at 0 in the first WAIT cycle, so it "reaches"
    // TIMEOUT on the cycle its current value is TIMEOUT-1.
    localparam logic [CW-1:0] C_CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [N-1:0]  C_ONE      = N'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t          r_state, w_state;
    logic [PW-1:0]   r_ptr,   w_ptr;
    logic [PW-1:0]   r_sel,   w_sel;
    logic [CW-1:0]   r_cnt,   w_cnt;
    logic [N-1:0]    w_ack;
    logic [W-1:0]    w_result;
    logic            w_err;
    logic            w_eng_load;
    logic [W-1:0]    w_eng_x, w_eng_y;

    logic            w_any;
    logic [PW-1:0]   w_win;
    logic [W-1:0]    w_xsel, w_ysel;
    logic [PW-1:0]   w_sel_next;
    int              idx;

    // Round-robin search: first set request at or above ptr, wrapping at N.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!w_any && req[idx[PW-1:0]]) begin
                w_any = 1'b1;
                w_win = idx[PW-1:0];
            end
        end
    end

    // Operand lane of the current winner.
    always_comb begin
        w_xsel = '0;
        w_ysel = '0;
        for (int k = 0; k < N; k++) begin
            if (w_win == PW'(k)) begin
                w_xsel = xin[k*W +: W];
                w_ysel = yin[k*W +: W];
            end
        end
    end

    assign w_sel_next = (r_sel == PW'(N - 1)) ? '0 : r_sel + PW'(1);

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        w_state    = r_state;
        w_ptr      = r_ptr;
        w_sel      = r_sel;
        w_cnt      = r_cnt;
        w_ack      = '0;
        w_result   = '0;
        w_err      = 1'b0;
        w_eng_load = 1'b0;
        w_eng_x    = eng_x;
        w_eng_y    = eng_y;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_sel = w_win;
                    if (w_xsel == '0 || w_ysel == '0) begin
                        // gcd(0,y)=y, gcd(x,0)=x; both zero falls out as 0.
                        w_state  = S_RESP;
                        w_ack    = C_ONE << w_win;
                        w_result = (w_xsel == '0) ? w_ysel : w_xsel;
                    end else begin
                        w_state    = S_LOAD;
                        w_eng_load = 1'b1;
                        w_eng_x    = w_xsel;
                        w_eng_y    = w_ysel;
                    end
                end
            end
            S_LOAD: begin
                w_state = S_WAIT;
                w_cnt   = '0;
            end
            S_WAIT: begin
                w_cnt = r_cnt + CW'(1);
                // eng_done is checked first so a same-cycle expiry loses.
                if (eng_done) begin
                    w_state  = S_RESP;
                    w_ack    = C_ONE << r_sel;
                    w_result = eng_gcd;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_state = S_RESP;
                    w_ack   = C_ONE << r_sel;
                    w_err   = 1'b1;
                end
            end
            S_RESP: begin
                w_state = S_IDLE;
                w_ptr   = w_sel_next;
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_sel    <= '0;
            r_cnt    <= '0;
            ack      <= '0;
            result   <= '0;
            err      <= 1'b0;
            eng_load <= 1'b0;
            eng_x    <= '0;
            eng_y    <= '0;
        end else begin
            r_state  <= w_state;
            r_ptr    <= w_ptr;
            r_sel    <= w_sel;
            r_cnt    <= w_cnt;
            ack      <= w_ack;
            result   <= w_result;
            err      <= w_err;
            eng_load <= w_eng_load;
            eng_x    <= w_eng_x;
            eng_y    <= w_eng_y;
        end
    end

    assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_gcd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gcd_arbiter
// Purpose  : Self-checking bench for gcd_arbiter (N=4, W=8, TIMEOUT=10)
//            with a behavioural GCD engine of programmable latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gcd_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] xin, yin;
    logic [N-1:0]   ack;
    logic [W-1:0]   result;
    logic           err, busy, eng_load;
    logic [W-1:0]   eng_x, eng_y;
    logic           eng_done;
    logic [W-1:0]   eng_gcd;

    gcd_arbiter #(.N(N), .W(W), .TIMEOUT(10)) dut (
        .clk(clk), .rst(rst), .req(req), .xin(xin), .yin(yin),
        .ack(ack), .result(result), .err(err), .busy(busy),
        .eng_load(eng_load), .eng_x(eng_x), .eng_y(eng_y),
        .eng_done(eng_done), .eng_gcd(eng_gcd)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // behavioural engine state
    int delay = 1;
    int ecnt  = 0;
    bit pend  = 0;
    int loads = 0;

    typedef struct {
        logic [N-1:0]   req;
        logic [N*W-1:0] xin;
        logic [N*W-1:0] yin;
        int             delay;
        logic [N-1:0]   exp_ack;
        logic [W-1:0]   exp_res;
        logic           exp_err;
        int             exp_lat;
        int             exp_loads;
    } vec_t;

    vec_t vecs[13];

    function automatic logic [W-1:0] gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic logic [N*W-1:0] lane(input int i, input logic [W-1:0] v,
                                            input logic [W-1:0] fill);
        logic [N*W-1:0] r;
        r = {N{fill}};
        r[i*W +: W] = v;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // One clock: advance past the edge, then update the engine model.
    task automatic step();
        @(posedge clk);
        #1;
        if (rst) begin
            pend     = 0;
            eng_done = 1'b0;
        end else if (eng_load) begin
            loads++;
            pend     = 1;
            ecnt     = delay;
            eng_done = 1'b0;
        end else if (pend) begin
            ecnt--;
            if (ecnt == 0) begin
                eng_done = 1'b1;
                eng_gcd  = gcd(eng_x, eng_y);
                pend     = 0;
            end else begin
                eng_done = 1'b0;
            end
        end else begin
            eng_done = 1'b0;
        end
    endtask

    // Present a request in IDLE (cycle 0), wait for ack, check it, return to IDLE.
    task automatic run_vec(input string nm, input vec_t v);
        int  cyc;
        bit  got;
        req   = v.req;
        xin   = v.xin;
        yin   = v.yin;
        delay = v.delay;
        loads = 0;
        cyc   = 0;
        got   = 0;
        while (cyc < 200 && !got) begin
            step();
            cyc++;
            if (ack != '0) got = 1;
        end
        chk({nm, " ack-seen"}, 64'(got), 64'd1);
        chk({nm, " ack"},      64'(ack), 64'(v.exp_ack));
        chk({nm, " result"},   64'(result), 64'(v.exp_res));
        chk({nm, " err"},      64'(err), 64'(v.exp_err));
        chk({nm, " latency"},  64'(cyc), 64'(v.exp_lat));
        chk({nm, " loads"},    64'(loads), 64'(v.exp_loads));
        step();
        chk({nm, " ack-1cyc"}, 64'({ack, busy}), 64'd0);
    endtask

    initial begin
        // fairness: all four requesting 12/8, engine 6 cycles after load
        for (int i = 0; i < 5; i++)
            vecs[i] = '{4'b1111, {N{8'd12}}, {N{8'd8}}, 6, 4'(1 << (i % 4)), 8'd4, 1'b0, 8, 1};
        // single request 48/18, ptr now 1 so search wraps back to 0
        vecs[5]  = '{4'b0001, lane(0, 8'd48, 8'hA5), lane(0, 8'd18, 8'h3C), 6, 4'b0001, 8'd6, 1'b0, 8, 1};
        // bypass cases
        vecs[6]  = '{4'b0100, lane(2, 8'd0, 8'hA5), lane(2, 8'd9, 8'h3C), 6, 4'b0100, 8'd9, 1'b0, 1, 0};
        vecs[7]  = '{4'b0100, lane(2, 8'd0, 8'hA5), lane(2, 8'd0, 8'h3C), 6, 4'b0100, 8'd0, 1'b0, 1, 0};
        vecs[8]  = '{4'b1000, lane(3, 8'd7, 8'hA5), lane(3, 8'd0, 8'h3C), 6, 4'b1000, 8'd7, 1'b0, 1, 0};
        // engine never answers: abort with err
        vecs[9]  = '{4'b0010, lane(1, 8'd35, 8'hA5), lane(1, 8'd14, 8'h3C), 1000, 4'b0010, 8'd0, 1'b1, 12, 1};
        // next request served normally
        vecs[10] = '{4'b0010, lane(1, 8'd35, 8'hA5), lane(1, 8'd14, 8'h3C), 3, 4'b0010, 8'd7, 1'b0, 5, 1};
        // done on the expiry cycle: done wins
        vecs[11] = '{4'b0001, lane(0, 8'd100, 8'hA5), lane(0, 8'd75, 8'h3C), 10, 4'b0001, 8'd25, 1'b0, 12, 1};
        // done one cycle too late: timeout
        vecs[12] = '{4'b0001, lane(0, 8'd100, 8'hA5), lane(0, 8'd75, 8'h3C), 11, 4'b0001, 8'd0, 1'b1, 12, 1};

        rst      = 1'b1;
        req      = '0;
        xin      = '0;
        yin      = '0;
        eng_done = 1'b0;
        eng_gcd  = '0;
        step();
        step();
        chk("reset outputs", 64'({ack, result, err, busy, eng_load, eng_x, eng_y}), 64'd0);
        rst = 1'b0;

        // idle with no requests
        step(); step(); step();
        chk("idle no req", 64'({ack, busy, eng_load}), 64'd0);

        for (int i = 0; i < 13; i++)
            run_vec($sformatf("v%0d", i), vecs[i]);

        // granted requester drops req before ack; ptr ends at 2
        begin
            int cyc;
            bit got;
            req   = 4'b0010;
            xin   = lane(1, 8'd21, 8'hA5);
            yin   = lane(1, 8'd14, 8'h3C);
            delay = 4;
            step();
            req = '0;
            cyc = 1;
            got = 0;
            while (cyc < 200 && !got) begin
                step();
                cyc++;
                if (ack != '0) got = 1;
            end
            chk("drop ack", 64'(ack), 64'b0010);
            chk("drop result", 64'(result), 64'd7);
            chk("drop latency", 64'(cyc), 64'd6);
            step();
        end

        // reset in the middle of WAIT
        req   = 4'b0100;
        xin   = lane(2, 8'd30, 8'hA5);
        yin   = lane(2, 8'd12, 8'h3C);
        delay = 1000;
        step(); step(); step();
        chk("pre-reset busy", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("async reset outputs", 64'({ack, result, err, busy, eng_load, eng_x, eng_y}), 64'd0);
        req = '0;
        step();
        chk("reset hold ack", 64'({ack, busy}), 64'd0);
        step();
        rst = 1'b0;
        step();
        chk("post-reset no ack", 64'({ack, busy}), 64'd0);
        run_vec("after-reset", '{4'b1111, {N{8'd12}}, {N{8'd8}}, 6, 4'b0001, 8'd4, 1'b0, 8, 1});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
